// File: rtl/sram_banked_ctrl.sv
// sram_banked_ctrl: multi-bank single-port SRAM with a valid/ready request port and a registered read response.
// After reset it clears every row of every bank in parallel (one row per cycle) and only then raises init_done/req_ready.
// Ports: clk, rst (async, active-high) | init_done | req_valid/req_ready/req_we/req_addr/req_wdata/req_be (request)
//        rd_valid/rd_data/rd_bank (read response, 1-cycle latency) | bank_sel (one-hot strobe of the accepted request)
module sram_banked_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 1024,
  parameter int NUM_BANKS = 4,
  parameter int BANK_MAP  = 0,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = $clog2(NUM_BANKS),
  localparam int ROWS = DEPTH / NUM_BANKS,
  localparam int RW   = AW - BW,
  localparam int BEW  = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [BEW-1:0]       req_be,
  output logic                 rd_valid,
  output logic [WIDTH-1:0]     rd_data,
  output logic [BW-1:0]        rd_bank,
  output logic [NUM_BANKS-1:0] bank_sel
);
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [RW-1:0] row_cnt;
  logic [WIDTH-1:0] mem [NUM_BANKS][ROWS];
  logic acc;
  logic [BW-1:0] bank;
  logic [RW-1:0] row;
  assign req_ready = init_done;
  assign acc = req_valid & init_done;
  assign bank = (BANK_MAP != 0) ? req_addr[BW-1:0] : req_addr[AW-1 -: BW];
  assign row = (BANK_MAP != 0) ? req_addr[AW-1:BW] : req_addr[RW-1:0];
  assign bank_sel = acc ? NUM_BANKS'(1) << bank : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= INIT;
      row_cnt   <= '0;
      init_done <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_bank   <= '0;
    end else begin
      rd_valid <= acc & ~req_we;
      if (acc & ~req_we) begin
        rd_data <= mem[bank][row];
        rd_bank <= bank;
      end
      if (state == INIT) begin
        row_cnt <= row_cnt + RW'(1);
        if (row_cnt == RW'(ROWS - 1)) begin
          state     <= READY;
          init_done <= 1'b1;
        end
      end
    end
  // Storage has no reset: the INIT sweep is what clears it.
  always_ff @(posedge clk)
    if (state == INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) mem[b][row_cnt] <= '0;
    end else if (acc & req_we) begin
      for (int i = 0; i < BEW; i++)
        if (req_be[i]) mem[bank][row][8*i +: 8] <= req_wdata[8*i +: 8];
    end
  a_sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bank_sel));
  a_no_early_acc: assert property (@(posedge clk) disable iff (rst) !(|bank_sel && !init_done));
  a_rd_after_acc: assert property (@(posedge clk) disable iff (rst) rd_valid |-> $past(acc && !req_we));
endmodule
